// File: rtl/dac_arbiter_if.sv
// Channel-request / SPI-serializer bundle shared by dac_arbiter and its environment.
// master = arbiter side, slave = requesters plus serializer side.
interface dac_arbiter_if;
  logic [3:0]  req;
  logic [47:0] value;
  logic [3:0]  ack;
  logic        tx_start;
  logic [31:0] tx_frame;
  logic        tx_done;
  logic        busy;
  logic [1:0]  cur_ch;
  logic        sample_tick;
  logic        err;

  modport master (
    input  req, value, tx_done,
    output ack, tx_start, tx_frame, busy, cur_ch, sample_tick, err
  );

  modport slave (
    output req, value, tx_done,
    input  ack, tx_start, tx_frame, busy, cur_ch, sample_tick, err
  );
endinterface

// File: rtl/dac_arbiter.sv
// Round-robin sequencer sharing one SPI DAC serializer among four channels, plus sample tick.
// Optional serializer watchdog is compiled in with `define DAC_ARB_TIMEOUT_EN.
module dac_arbiter #(
  parameter int unsigned DIV     = 50000,
  parameter logic [3:0]  CMD     = 4'b0011,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dac_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

  generate
    if (DIV < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("dac_arbiter: DIV must be >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  state_t           r_state, w_next;
  logic [1:0]       r_last, r_cur_ch;
  logic [31:0]      r_frame;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [1:0]       w_winner, w_idx;
  logic             w_any, w_capture;
  logic [11:0]      w_sample;
  logic             w_wd_expire;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    w_winner = r_last;
    w_any    = 1'b0;
    w_idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_any && bus.req[w_idx]) begin
        w_winner = w_idx;
        w_any    = 1'b1;
      end
    end
  end

  always_comb begin
    case (w_winner)
      2'd0:    w_sample = bus.value[11:0];
      2'd1:    w_sample = bus.value[23:12];
      2'd2:    w_sample = bus.value[35:24];
      default: w_sample = bus.value[47:36];
    endcase
  end

`ifdef DAC_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  assign w_wd_expire = (r_state == S_WAIT) && (r_wd_cnt == WD_W'(TIMEOUT - 1));

  // A tx_done coinciding with the limit counts as a normal completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)
        r_wd_cnt <= '0;
      else if (r_state == S_WAIT)
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_expire && !bus.tx_done)
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_wd_expire = 1'b0;
  assign bus.err     = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next    = S_LAUNCH;
          w_capture = 1'b1;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done || w_wd_expire)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 2'd3;
      r_cur_ch <= 2'd0;
      r_frame  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_cur_ch <= w_winner;
        r_frame  <= {8'h00, CMD, 2'b00, w_winner, w_sample, 4'h0};
      end
      if (r_state == S_LAUNCH)
        r_last <= r_cur_ch;
    end
  end

  // Free-running sample tick, independent of arbitration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_tick_cnt <= '0;
    else if (r_tick_cnt == TICK_LAST)
      r_tick_cnt <= '0;
    else
      r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign bus.ack         = (r_state == S_LAUNCH) ? (4'b0001 << r_cur_ch) : 4'b0000;
  assign bus.tx_start    = (r_state == S_LAUNCH);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.tx_frame    = r_frame;
  assign bus.cur_ch      = r_cur_ch;
  assign bus.sample_tick = (r_tick_cnt == TICK_LAST);

endmodule
